// File: rtl/cmos_capture_data_pkg.sv
// Shared camera definitions used by the capture blocks and the dual-camera merger.
//   WAIT_FRAME_DEFAULT : vsync rising edges to skip after reset while the OV5640 settles
//   R_W / G_W / B_W    : RGB565 field widths
//   rgb565_t           : packed RGB565 pixel, red in the MSBs
package cmos_capture_data_pkg;

  localparam logic [3:0]  WAIT_FRAME_DEFAULT = 4'd10;

  localparam int unsigned R_W   = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_W   = 5;
  localparam int unsigned PIX_W = R_W + G_W + B_W;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

endpackage

// File: rtl/cmos_capture_data_if.sv
// DVP camera input and captured-frame output bundle for one camera.
//   cmos_vsync/href/data       : raw DVP signals from the sensor
//   cmos_frame_vsync/href      : delayed sync, gated until the sensor has settled
//   cmos_frame_valid/data      : one-cycle strobe with an assembled RGB565 pixel
//   line_width / frame_height  : pixel count of last line, line count of last frame
//   odd_err                    : pulse when a line ended on an odd byte
// slave is the capture block, master is the sensor/consumer side.
interface cmos_capture_data_if
  import cmos_capture_data_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) ();

  logic             cmos_vsync;
  logic             cmos_href;
  logic [7:0]       cmos_data;
  logic             cmos_frame_vsync;
  logic             cmos_frame_href;
  logic             cmos_frame_valid;
  logic [PIX_W-1:0] cmos_frame_data;
  logic [CNT_W-1:0] line_width;
  logic [CNT_W-1:0] frame_height;
  logic             odd_err;

  modport master (
    output cmos_vsync, cmos_href, cmos_data,
    input  cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
    input  line_width, frame_height, odd_err
  );

  modport slave (
    input  cmos_vsync, cmos_href, cmos_data,
    output cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, cmos_frame_data,
    output line_width, frame_height, odd_err
  );

endinterface

// File: rtl/cmos_capture_data.sv
// OV5640 DVP capture: registers the byte stream, pairs bytes into RGB565 pixels, skips the
// first WAIT_FRAME frames after reset and measures line width / frame height.
//   cmos_pclk : pixel clock, all logic on its rising edge
//   rst_n     : asynchronous active-low reset
//   cam       : DVP inputs and captured-frame outputs (slave side)
// Pixel latency is two registers: input stage, then the pixel/valid register.
module cmos_capture_data
  import cmos_capture_data_pkg::*;
#(
  parameter logic [3:0]  WAIT_FRAME = WAIT_FRAME_DEFAULT,
  parameter int unsigned CNT_W      = 11
) (
  input  logic               cmos_pclk,
  input  logic               rst_n,
  cmos_capture_data_if.slave cam
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Input pipeline
  logic       vsync_s1_q, vsync_s2_q;
  logic       href_s1_q, href_s2_q;
  logic [7:0] data_s1_q;

  logic       frame_ok_q, frame_ok_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic       byte_flag_q, byte_flag_d;
  logic [7:0] high_byte_q, high_byte_d;

  rgb565_t    frame_data_q, frame_data_d;
  logic       frame_valid_q, frame_valid_d;
  logic       odd_err_q, odd_err_d;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d, line_cnt_inc;
  logic [CNT_W-1:0] line_width_q, line_width_d;
  logic [CNT_W-1:0] frame_height_q, frame_height_d;

  logic vsync_rise, href_fall, pix_strobe;

  assign vsync_rise = vsync_s1_q & ~vsync_s2_q;
  assign href_fall  = ~href_s1_q & href_s2_q;
  // Second byte of a pair is in stage 1
  assign pix_strobe = href_s1_q & byte_flag_q;

  always_comb begin
    frame_cnt_d    = frame_cnt_q;
    frame_ok_d     = frame_ok_q | (frame_cnt_q == WAIT_FRAME);
    byte_flag_d    = href_s1_q ? ~byte_flag_q : 1'b0;
    high_byte_d    = high_byte_q;
    frame_data_d   = frame_data_q;
    frame_valid_d  = 1'b0;
    odd_err_d      = href_fall & byte_flag_q;
    pix_cnt_d      = pix_cnt_q;
    line_width_d   = line_width_q;
    line_cnt_inc   = line_cnt_q;
    line_cnt_d     = line_cnt_q;
    frame_height_d = frame_height_q;

    if (vsync_rise && (frame_cnt_q != WAIT_FRAME)) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
    end

    if (href_s1_q && !byte_flag_q) begin
      high_byte_d = data_s1_q;
    end

    // Pixels are still counted before frame_ok; only the outputs are gated.
    if (pix_strobe && frame_ok_q) begin
      frame_data_d  = rgb565_t'({high_byte_q, data_s1_q});
      frame_valid_d = 1'b1;
    end

    if (href_fall) begin
      line_width_d = pix_cnt_q;
      pix_cnt_d    = '0;
    end else if (pix_strobe && (pix_cnt_q != CntMax)) begin
      pix_cnt_d = pix_cnt_q + CntOne;
    end

    // A line ending in the same cycle as vsync rises still belongs to the old frame.
    if (href_fall && (line_cnt_q != CntMax)) begin
      line_cnt_inc = line_cnt_q + CntOne;
    end
    if (vsync_rise) begin
      frame_height_d = line_cnt_inc;
      line_cnt_d     = '0;
    end else begin
      line_cnt_d = line_cnt_inc;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1_q     <= 1'b0;
      vsync_s2_q     <= 1'b0;
      href_s1_q      <= 1'b0;
      href_s2_q      <= 1'b0;
      data_s1_q      <= '0;
      frame_ok_q     <= 1'b0;
      frame_cnt_q    <= '0;
      byte_flag_q    <= 1'b0;
      high_byte_q    <= '0;
      frame_data_q   <= '0;
      frame_valid_q  <= 1'b0;
      odd_err_q      <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      line_width_q   <= '0;
      frame_height_q <= '0;
    end else begin
      vsync_s1_q     <= cam.cmos_vsync;
      vsync_s2_q     <= vsync_s1_q;
      href_s1_q      <= cam.cmos_href;
      href_s2_q      <= href_s1_q;
      data_s1_q      <= cam.cmos_data;
      frame_ok_q     <= frame_ok_d;
      frame_cnt_q    <= frame_cnt_d;
      byte_flag_q    <= byte_flag_d;
      high_byte_q    <= high_byte_d;
      frame_data_q   <= frame_data_d;
      frame_valid_q  <= frame_valid_d;
      odd_err_q      <= odd_err_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      line_width_q   <= line_width_d;
      frame_height_q <= frame_height_d;
    end
  end

  assign cam.cmos_frame_vsync = vsync_s2_q & frame_ok_q;
  assign cam.cmos_frame_href  = href_s2_q & frame_ok_q;
  assign cam.cmos_frame_valid = frame_valid_q;
  assign cam.cmos_frame_data  = frame_data_q;
  assign cam.line_width       = line_width_q;
  assign cam.frame_height     = frame_height_q;
  assign cam.odd_err          = odd_err_q;

endmodule

// File: tb/tb_cmos_capture_data.sv
// Directed bench for cmos_capture_data: settle-frame skipping, pixel pairing table,
// line/frame measurement, saturation, odd lines and mid-line reset.
module tb_cmos_capture_data;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cmos_capture_data_if #(.CNT_W(11)) cam ();

  cmos_capture_data #(
    .WAIT_FRAME(4'd10),
    .CNT_W     (11)
  ) dut (
    .cmos_pclk(clk),
    .rst_n    (rst_n),
    .cam      (cam)
  );

  typedef struct packed {
    logic        h;
    logic [7:0]  d;
    logic        ev;
    logic [15:0] ed;
    logic        eo;
    logic        eh;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt;
  int vs_out_cnt;
  vec_t vt[20];

  function automatic vec_t mk(logic h, logic [7:0] d, logic ev, logic [15:0] ed,
                              logic eo, logic eh);
    vec_t v;
    v.h = h; v.d = d; v.ev = ev; v.ed = ed; v.eo = eo; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, observe 1 ns later.
  task automatic step(input logic v, input logic h, input logic [7:0] d);
    cam.cmos_vsync = v;
    cam.cmos_href  = h;
    cam.cmos_data  = d;
    @(posedge clk);
    #1;
    if (cam.cmos_frame_valid) valid_cnt++;
    if (cam.cmos_frame_vsync) vs_out_cnt++;
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'(base + 8'(i)));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(cam.cmos_frame_valid), 32'd0);
    chk({tag, "_data"},  32'(cam.cmos_frame_data),  32'd0);
    chk({tag, "_vsync"}, 32'(cam.cmos_frame_vsync), 32'd0);
    chk({tag, "_href"},  32'(cam.cmos_frame_href),  32'd0);
    chk({tag, "_lw"},    32'(cam.line_width),       32'd0);
    chk({tag, "_fh"},    32'(cam.frame_height),     32'd0);
    chk({tag, "_odd"},   32'(cam.odd_err),          32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 4-byte line, 5-byte (odd) line, then a 2-byte line to check re-pairing.
    vt[0]  = mk(1'b1, 8'hF8, 1'b0, 16'h0000, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1);
    vt[2]  = mk(1'b1, 8'h07, 1'b1, 16'hF800, 1'b0, 1'b1);
    vt[3]  = mk(1'b1, 8'hE0, 1'b0, 16'hF800, 1'b0, 1'b1);
    vt[4]  = mk(1'b0, 8'h00, 1'b1, 16'h07E0, 1'b0, 1'b1);
    vt[5]  = mk(1'b0, 8'h00, 1'b0, 16'h07E0, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 8'h00, 1'b0, 16'h07E0, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 8'hA1, 1'b0, 16'h07E0, 1'b0, 1'b0);
    vt[8]  = mk(1'b1, 8'hB2, 1'b0, 16'h07E0, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 8'hC3, 1'b1, 16'hA1B2, 1'b0, 1'b1);
    vt[10] = mk(1'b1, 8'hD4, 1'b0, 16'hA1B2, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 8'hE5, 1'b1, 16'hC3D4, 1'b0, 1'b1);
    vt[12] = mk(1'b0, 8'h00, 1'b0, 16'hC3D4, 1'b0, 1'b1);
    vt[13] = mk(1'b0, 8'h00, 1'b0, 16'hC3D4, 1'b1, 1'b0);
    vt[14] = mk(1'b0, 8'h00, 1'b0, 16'hC3D4, 1'b0, 1'b0);
    vt[15] = mk(1'b1, 8'h12, 1'b0, 16'hC3D4, 1'b0, 1'b0);
    vt[16] = mk(1'b1, 8'h34, 1'b0, 16'hC3D4, 1'b0, 1'b1);
    vt[17] = mk(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b1);
    vt[18] = mk(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 1'b0);
    vt[19] = mk(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 1'b0);

    cam.cmos_vsync = 1'b0;
    cam.cmos_href  = 1'b0;
    cam.cmos_data  = 8'h00;
    valid_cnt  = 0;
    vs_out_cnt = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // Nine settle frames: nothing may come out
    for (int f = 0; f < 9; f++) begin
      vsync_pulse();
      send_line(4, 8'h40);
      send_line(4, 8'h50);
    end
    chk("settle_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("settle_vsync_cnt", 32'(vs_out_cnt), 32'd0);

    // Tenth vsync releases the outputs
    vsync_pulse();
    chk("tenth_vsync_seen", 32'(vs_out_cnt > 0), 32'd1);

    // Pixel pairing table
    for (int i = 0; i < 20; i++) begin
      step(1'b0, vt[i].h, vt[i].d);
      chk($sformatf("vec%0d_valid", i), 32'(cam.cmos_frame_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_data", i),  32'(cam.cmos_frame_data),  32'(vt[i].ed));
      chk($sformatf("vec%0d_odd", i),   32'(cam.odd_err),          32'(vt[i].eo));
      chk($sformatf("vec%0d_href", i),  32'(cam.cmos_frame_href),  32'(vt[i].eh));
    end
    chk("table_lw", 32'(cam.line_width), 32'd1);

    // Three table lines belong to the frame closed by this vsync
    vsync_pulse();
    chk("fh_table_frame", 32'(cam.frame_height), 32'd3);

    // 1280-byte line, then 479 short lines
    valid_cnt = 0;
    send_line(1280, 8'h00);
    chk("lw_1280", 32'(cam.line_width), 32'd640);
    chk("valid_1280", 32'(valid_cnt), 32'd640);
    for (int l = 0; l < 479; l++) send_line(4, 8'h10);
    vsync_pulse();
    chk("fh_480", 32'(cam.frame_height), 32'd480);
    vsync_pulse();
    chk("fh_cleared", 32'(cam.frame_height), 32'd0);

    // href falls in the same cycle vsync rises: line still counted
    send_line(4, 8'h20);
    send_line(4, 8'h30);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h60 + 8'(i)));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    chk("fh_simul", 32'(cam.frame_height), 32'd3);
    chk("lw_simul", 32'(cam.line_width), 32'd2);

    // Pixel counter saturation, then clear on next line
    send_line(5000, 8'h00);
    chk("lw_sat", 32'(cam.line_width), 32'd2047);
    send_line(6, 8'h00);
    chk("lw_after_sat", 32'(cam.line_width), 32'd3);

    // Line counter saturation
    vsync_pulse();
    for (int l = 0; l < 2050; l++) send_line(2, 8'h00);
    vsync_pulse();
    chk("fh_sat", 32'(cam.frame_height), 32'd2047);

    // Mid-line reset after frame_ok
    send_line(4, 8'h70);
    step(1'b0, 1'b1, 8'hAB);
    step(1'b0, 1'b1, 8'hCD);
    step(1'b0, 1'b1, 8'hEF);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    #2 rst_n = 1'b1;
    valid_cnt  = 0;
    vs_out_cnt = 0;
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
    for (int f = 0; f < 9; f++) begin
      vsync_pulse();
      send_line(4, 8'h80);
    end
    chk("rst_settle_valid", 32'(valid_cnt), 32'd0);
    vsync_pulse();
    valid_cnt = 0;
    send_line(4, 8'h90);
    chk("rst_after_valid", 32'(valid_cnt), 32'd2);
    chk("rst_after_data", 32'(cam.cmos_frame_data), 32'h9293);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_capture_data.md
CMOS_CAPTURE_DATA -- requirements
Module: cmos_capture_data

Interface
REQ-001 Parameter WAIT_FRAME, default 4'd10, number of vsync rising edges ignored after reset while OV5640 registers settle.
REQ-002 Parameter CNT_W, default 11, width of the pixel and line counters.
REQ-003 cmos_pclk  in  1  sole clock (camera pixel clock); all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 cmos_vsync  in  1  camera frame sync, active-high.
REQ-006 cmos_href  in  1  camera line valid, active-high.
REQ-007 cmos_data  in  8  camera DVP byte.
REQ-008 cmos_frame_vsync  out  1  delayed vsync, gated by frame_ok.
REQ-009 cmos_frame_href  out  1  delayed href, gated by frame_ok.
REQ-010 cmos_frame_valid  out  1  one-cycle strobe, a new RGB565 pixel is on cmos_frame_data.
REQ-011 cmos_frame_data  out  16  RGB565 pixel, {first byte, second byte}.
REQ-012 line_width  out  CNT_W  pixel count of the last completed line.
REQ-013 frame_height  out  CNT_W  line count of the last completed frame.
REQ-014 odd_err  out  1  one-cycle pulse, a line ended with an odd byte count.

Function
REQ-015 Inputs SHALL be registered once (stage 1); vsync/href edges SHALL be detected from stage 1 versus stage 2.
REQ-016 frame_cnt SHALL increment on each vsync rising edge until it equals WAIT_FRAME; frame_ok SHALL then set and hold until reset.
REQ-017 byte_flag SHALL toggle on each stage-1 href-high cycle and clear whenever stage-1 href is low.
REQ-018 With byte_flag=0 the byte SHALL be stored as the high byte; with byte_flag=1 the pixel {high, byte} SHALL be registered.
REQ-019 Latency: second byte on cmos_data at edge k -> cmos_frame_data and cmos_frame_valid at edge k+2; valid high for exactly one cycle.
REQ-020 cmos_frame_vsync/href SHALL be stage-2 vsync/href ANDed with frame_ok, aligned with the 2-cycle pixel latency.
REQ-021 cmos_frame_valid SHALL be forced 0 while frame_ok=0; cmos_frame_data holds its last value when valid is 0.
REQ-022 pix_cnt SHALL increment per assembled pixel, saturate at 2^CNT_W-1, clear on href falling edge after being latched into line_width.
REQ-023 On href falling edge with byte_flag=1 (odd bytes) odd_err SHALL pulse one cycle; the dangling byte is discarded.
REQ-024 line_cnt SHALL increment on href falling edge, saturate at 2^CNT_W-1; on vsync rising edge it SHALL be latched into frame_height, then cleared.
REQ-025 Simultaneous vsync rising and href falling: href falling processed first (line counted), then latch/clear, in the same cycle.
REQ-026 href high while vsync high SHALL still assemble pixels; only gating by frame_ok applies.

Reset
REQ-027 rst_n low SHALL asynchronously clear all registers: outputs 0, frame_ok 0, frame_cnt 0, byte_flag 0, counters 0.
REQ-028 Reset mid-frame SHALL restart the WAIT_FRAME count; no partial pixel or valid SHALL emerge after release.

Structure
REQ-029 WAIT_FRAME default and RGB565 field widths (R5/G6/B5) SHALL live in the shared camera package used by the dual-camera merger.
REQ-030 Single module, no sub-modules; one instance per camera (cmos0, cmos1) feeding the downstream merger.

Verification
REQ-031 Reset release, 9 vsync pulses with 4-byte lines -> cmos_frame_valid never asserts; 10th pulse -> frame_ok=1, next frame's pixels output.
REQ-032 After frame_ok, href line of bytes 0xF8,0x00,0x07,0xE0 -> two valid strobes, data 0xF800 then 0x07E0, each 2 cycles after its second byte.
REQ-033 Line of 1280 bytes -> line_width=640 after href falls; 480 such lines then vsync rise -> frame_height=480, line_cnt=0.
REQ-034 Line of 5 bytes -> 2 valid strobes, odd_err pulses once, next line's first pixel correctly paired.
REQ-035 rst_n low mid-line after frame_ok -> all outputs 0 immediately; after release, 10 vsync pulses required before valid reasserts.
REQ-036 Line of 5000 bytes -> pix_cnt saturates, line_width=2047.
